// File: rtl/reg_file_pkg.sv
// Shared constants for the two-port configuration register file.
package reg_file_pkg;

    // Legal read pipeline depths
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Reset defaults: UART config (parity on, even, 8 data bits) and clock divider
    localparam logic [31:0] CFG_RST_DEF = 32'h0000_0021;
    localparam logic [31:0] DIV_RST_DEF = 32'h0000_0008;

    // UART configuration register field positions
    localparam int CFG_PAR_EN_BIT   = 0;
    localparam int CFG_PAR_TYPE_BIT = 1;
    localparam int CFG_DW_LSB       = 2;
    localparam int CFG_DW_MSB       = 6;

    // True when the requested read latency is supported
    function automatic bit rd_latency_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/reg_file_rd_pipe.sv
// Read return pipeline carrying {valid, err, data}; data holds when no read moves.
module reg_file_rd_pipe
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic                  i_err,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [STAGES-1:0]     r_valid;
    logic [STAGES-1:0]     r_err;
    logic [DATA_WIDTH-1:0] r_data [STAGES];

    // Shift valid/err every cycle; data only advances behind a valid so outputs hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= {STAGES{1'b0}};
            r_err   <= {STAGES{1'b0}};
            for (int s = 0; s < STAGES; s++) begin
                r_data[s] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            r_valid[0] <= i_valid;
            r_err[0]   <= i_valid & i_err;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int s = 1; s < STAGES; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_err[s]   <= r_valid[s-1] & r_err[s-1];
                if (r_valid[s-1]) begin
                    r_data[s] <= r_data[s-1];
                end
            end
        end
    end

    assign o_valid = r_valid[STAGES-1];
    assign o_err   = r_err[STAGES-1];
    assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/reg_file_2p.sv
// Two-port configuration register file: byte-enable writes, write-first
// forwarding, out-of-range detection and a 1- or 2-cycle read return.
module reg_file_2p
    import reg_file_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   DEPTH      = 16,
    parameter int                   ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int                   RD_LATENCY = 1,
    parameter int                   CFG_IDX    = 2,
    parameter logic [DATA_WIDTH-1:0] CFG_RST   = DATA_WIDTH'(CFG_RST_DEF),
    parameter int                   DIV_IDX    = 3,
    parameter logic [DATA_WIDTH-1:0] DIV_RST   = DATA_WIDTH'(DIV_RST_DEF)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    WrEN,
    input  logic [ADDR_WIDTH-1:0]   WrAddr,
    input  logic [DATA_WIDTH-1:0]   WrData,
    input  logic [DATA_WIDTH/8-1:0] WrBE,
    input  logic                    RdEN,
    input  logic [ADDR_WIDTH-1:0]   RdAddr,
    output logic [DATA_WIDTH-1:0]   RdData,
    output logic                    RdData_Valid,
    output logic                    RdErr,
    output logic                    WrErr
);

    localparam int NB      = DATA_WIDTH / 8;
    localparam int LP_SPAN = 32'sd1 << ADDR_WIDTH;

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_lat
        $fatal(1, "reg_file_2p: RD_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $fatal(1, "reg_file_2p: DATA_WIDTH must be a multiple of 8");
    end
    if ((CFG_IDX >= DEPTH) || (DIV_IDX >= DEPTH)) begin : g_bad_idx
        $fatal(1, "reg_file_2p: CFG_IDX/DIV_IDX outside the array");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_wr_err;
    logic                  w_wr_in;
    logic                  w_rd_in;
    logic                  w_wr_ok;
    logic                  w_fwd;
    logic [DATA_WIDTH-1:0] w_rd_raw;
    logic [DATA_WIDTH-1:0] w_rd_merged;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Full address span in use: every address is legal, no comparator needed
    if (DEPTH == LP_SPAN) begin : g_pow2
        assign w_wr_in = 1'b1;
        assign w_rd_in = 1'b1;
    end else begin : g_range
        localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
        assign w_wr_in = ({1'b0, WrAddr} < LP_DEPTH);
        assign w_rd_in = ({1'b0, RdAddr} < LP_DEPTH);
    end

    assign w_wr_ok = WrEN & w_wr_in;
    assign w_fwd   = w_wr_ok & (WrAddr == RdAddr);

    // Reset image of register idx
    function automatic logic [DATA_WIDTH-1:0] rst_val(input int idx);
        if (idx == CFG_IDX) begin
            return CFG_RST;
        end else if (idx == DIV_IDX) begin
            return DIV_RST;
        end else begin
            return {DATA_WIDTH{1'b0}};
        end
    endfunction

    // Register array with per-byte write enables
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= rst_val(i);
            end
        end else if (w_wr_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (WrAddr == ADDR_WIDTH'(i)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (WrBE[b]) begin
                            r_mem[i][8*b +: 8] <= WrData[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux over the populated registers
    always_comb begin
        w_rd_raw = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (RdAddr == ADDR_WIDTH'(i)) begin
                w_rd_raw = r_mem[i];
            end else begin
                w_rd_raw = w_rd_raw;
            end
        end
    end

    // Write-first merge: bytes being written this cycle bypass the array
    always_comb begin
        w_rd_merged = w_rd_raw;
        for (int b = 0; b < NB; b++) begin
            if (w_fwd && WrBE[b]) begin
                w_rd_merged[8*b +: 8] = WrData[8*b +: 8];
            end else begin
                w_rd_merged[8*b +: 8] = w_rd_raw[8*b +: 8];
            end
        end
    end

    // Out-of-range reads return zero
    always_comb begin
        w_rd_data = {DATA_WIDTH{1'b0}};
        if (w_rd_in) begin
            w_rd_data = w_rd_merged;
        end else begin
            w_rd_data = {DATA_WIDTH{1'b0}};
        end
    end

    // One-cycle error pulse for writes that miss the array
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= WrEN & ~w_wr_in;
        end
    end

    assign WrErr = r_wr_err;

    reg_file_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .i_valid (RdEN),
        .i_err   (~w_rd_in),
        .i_data  (w_rd_data),
        .o_valid (RdData_Valid),
        .o_err   (RdErr),
        .o_data  (RdData)
    );

endmodule

// File: tb/tb_reg_file_2p.sv
// Directed bench: three instances (16 regs/lat 1, 16 regs/lat 2, 12 regs/lat 1)
// share one stimulus stream; each is checked against hand-computed values.
module tb_reg_file_2p;

    logic        clk;
    logic        reset;
    logic        WrEN;
    logic [3:0]  WrAddr;
    logic [31:0] WrData;
    logic [3:0]  WrBE;
    logic        RdEN;
    logic [3:0]  RdAddr;

    logic [31:0] a_data, b_data, c_data;
    logic        a_vld, b_vld, c_vld;
    logic        a_err, b_err, c_err;
    logic        a_werr, b_werr, c_werr;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_mem [16];

    reg_file_2p #(.DATA_WIDTH(32), .DEPTH(16), .RD_LATENCY(1)) u_a (
        .clk(clk), .reset(reset), .WrEN(WrEN), .WrAddr(WrAddr), .WrData(WrData),
        .WrBE(WrBE), .RdEN(RdEN), .RdAddr(RdAddr), .RdData(a_data),
        .RdData_Valid(a_vld), .RdErr(a_err), .WrErr(a_werr));

    reg_file_2p #(.DATA_WIDTH(32), .DEPTH(16), .RD_LATENCY(2)) u_b (
        .clk(clk), .reset(reset), .WrEN(WrEN), .WrAddr(WrAddr), .WrData(WrData),
        .WrBE(WrBE), .RdEN(RdEN), .RdAddr(RdAddr), .RdData(b_data),
        .RdData_Valid(b_vld), .RdErr(b_err), .WrErr(b_werr));

    reg_file_2p #(.DATA_WIDTH(32), .DEPTH(12), .RD_LATENCY(1)) u_c (
        .clk(clk), .reset(reset), .WrEN(WrEN), .WrAddr(WrAddr), .WrData(WrData),
        .WrBE(WrBE), .RdEN(RdEN), .RdAddr(RdAddr), .RdData(c_data),
        .RdData_Valid(c_vld), .RdErr(c_err), .WrErr(c_werr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WrEN = 1'b0; WrAddr = 4'd0; WrData = 32'd0; WrBE = 4'd0;
        RdEN = 1'b0; RdAddr = 4'd0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #2;
        check_eq("rst_a_data", a_data, 32'd0);
        check_eq("rst_a_vld",  32'(a_vld), 32'd0);
        check_eq("rst_b_vld",  32'(b_vld), 32'd0);
        check_eq("rst_c_err",  32'(c_err), 32'd0);
        check_eq("rst_c_werr", 32'(c_werr), 32'd0);
        cyc(); cyc();
        reset = 1'b1;
        cyc();

        // Reset defaults, back-to-back reads at latency 1
        for (int a = 0; a < 16; a++) begin
            exp_mem[a] = (a == 2) ? 32'h21 : (a == 3) ? 32'h08 : 32'h0;
        end
        for (int a = 0; a < 16; a++) begin
            RdEN = 1'b1; RdAddr = 4'(a);
            cyc();
            check_eq($sformatf("dflt_vld%0d", a), 32'(a_vld), 32'd1);
            check_eq($sformatf("dflt_dat%0d", a), a_data, exp_mem[a]);
            check_eq($sformatf("d12_err%0d", a), 32'(c_err), (a >= 12) ? 32'd1 : 32'd0);
        end
        idle();
        cyc();
        check_eq("idle_a_vld", 32'(a_vld), 32'd0);

        // Byte-enable merge onto 0x11223344
        WrEN = 1'b1; WrAddr = 4'd5; WrData = 32'h1122_3344; WrBE = 4'hF;
        cyc();
        WrData = 32'hAABB_CCDD; WrBE = 4'b0101;
        cyc();
        idle();
        RdEN = 1'b1; RdAddr = 4'd5;
        cyc();
        check_eq("be_a_dat", a_data, 32'h11BB_33DD);
        idle();
        cyc();
        check_eq("hold_a_vld", 32'(a_vld), 32'd0);
        check_eq("hold_a_dat", a_data, 32'h11BB_33DD);
        check_eq("lat2_b_vld", 32'(b_vld), 32'd1);
        check_eq("lat2_b_dat", b_data, 32'h11BB_33DD);

        // WrBE = 0 is a silent no-op
        WrEN = 1'b1; WrAddr = 4'd5; WrData = 32'h0; WrBE = 4'h0;
        cyc();
        idle();
        check_eq("be0_werr", 32'(a_werr), 32'd0);
        RdEN = 1'b1; RdAddr = 4'd5;
        cyc();
        check_eq("be0_dat", a_data, 32'h11BB_33DD);
        idle();

        // Same-cycle write and read of address 7
        WrEN = 1'b1; WrAddr = 4'd7; WrData = 32'hDEAD_BEEF; WrBE = 4'hF;
        RdEN = 1'b1; RdAddr = 4'd7;
        cyc();
        check_eq("fwd_full", a_data, 32'hDEAD_BEEF);
        WrEN = 1'b0;
        cyc();
        check_eq("fwd_after", a_data, 32'hDEAD_BEEF);
        WrEN = 1'b1; WrData = 32'h0; WrBE = 4'b0011;
        cyc();
        check_eq("fwd_part", a_data, 32'hDEAD_0000);
        idle();
        cyc();

        // Latency-2 back-to-back reads of 1,2,3
        RdEN = 1'b1; RdAddr = 4'd1;
        cyc();
        check_eq("b2b_c1_vld", 32'(b_vld), 32'd0);
        RdAddr = 4'd2;
        cyc();
        check_eq("b2b_c2_vld", 32'(b_vld), 32'd1);
        check_eq("b2b_c2_dat", b_data, 32'h0);
        RdAddr = 4'd3;
        cyc();
        check_eq("b2b_c3_vld", 32'(b_vld), 32'd1);
        check_eq("b2b_c3_dat", b_data, 32'h21);
        idle();
        cyc();
        check_eq("b2b_c4_vld", 32'(b_vld), 32'd1);
        check_eq("b2b_c4_dat", b_data, 32'h08);
        cyc();
        check_eq("b2b_c5_vld", 32'(b_vld), 32'd0);

        // Out-of-range write on the 12-deep instance
        WrEN = 1'b1; WrAddr = 4'd13; WrData = 32'hFFFF_FFFF; WrBE = 4'hF;
        cyc();
        idle();
        check_eq("oor_c_werr", 32'(c_werr), 32'd1);
        check_eq("oor_a_werr", 32'(a_werr), 32'd0);
        cyc();
        check_eq("oor_c_werr_end", 32'(c_werr), 32'd0);
        exp_mem[5] = 32'h11BB_33DD;
        exp_mem[7] = 32'hDEAD_0000;
        for (int a = 0; a < 12; a++) begin
            RdEN = 1'b1; RdAddr = 4'(a);
            cyc();
            check_eq($sformatf("oor_c_dat%0d", a), c_data, exp_mem[a]);
        end
        RdAddr = 4'd13;
        cyc();
        check_eq("a13_dat", a_data, 32'hFFFF_FFFF);
        RdAddr = 4'd14;
        cyc();
        check_eq("c14_vld", 32'(c_vld), 32'd1);
        check_eq("c14_err", 32'(c_err), 32'd1);
        check_eq("c14_dat", c_data, 32'h0);
        check_eq("a14_err", 32'(a_err), 32'd0);
        idle();
        cyc();
        check_eq("c_err_idle", 32'(c_err), 32'd0);

        // Reset while a latency-2 read is in flight
        RdEN = 1'b1; RdAddr = 4'd2;
        cyc();
        idle();
        reset = 1'b0;
        #1;
        check_eq("mid_b_vld", 32'(b_vld), 32'd0);
        check_eq("mid_b_dat", b_data, 32'h0);
        cyc(); cyc();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_eq($sformatf("post_b_vld%0d", k), 32'(b_vld), 32'd0);
            check_eq($sformatf("post_b_dat%0d", k), b_data, 32'h0);
            check_eq($sformatf("post_a_dat%0d", k), a_data, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
